// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port instruction memory: fetch (read-only)
// and debug/loader (read/write), with a starvation counter, a debug lock and a read-return tag.
module imem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       lock_q, lock_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_dbg_q, rd_dbg_d;

  // Request stage: combinational grant and memory strobe
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (lock_q) begin
        d_gnt = d_req;
      end else if (f_req && d_req) begin
        if (wait_cnt_q == MAX_WAIT_C) d_gnt = 1'b1;
        else                          f_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (d_req && !d_gnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
    // Lock only takes hold once debug actually owns a cycle; it persists while d_lock stays high.
    lock_d   = d_lock & (lock_q | d_gnt);
    rd_vld_d = f_gnt | (d_gnt & ~d_we);
    rd_dbg_d = d_gnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_dbg_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      rd_vld_q   <= rd_vld_d;
      rd_dbg_q   <= rd_dbg_d;
    end
  end

  // Return stage: steer the registered memory read to the owner recorded in the tag
  always_comb begin
    f_rvalid = rst_n & rd_vld_q & ~rd_dbg_q;
    d_rvalid = rst_n & rd_vld_q & rd_dbg_q;
    f_rdata  = f_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the core fetch port (read-only) and the debug/program-loader port (read/write).
- Issues at most one memory access per cycle and routes the returning read data to the requester that issued it.
- Fetch has default priority. A starvation counter and a debug lock let the loader preload or patch the program at run time.
- Sits between the fetch stage/loader and the instruction memory macro, which has a registered read (1-cycle latency).

Parameters:
- ADDR_W, 9, word address width (512 locations).
- DATA_W, 32, instruction word width.
- MAX_WAIT, 4, number of consecutive denied debug cycles before debug wins a contended cycle (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_W  fetch read data.
- d_req  in  1  debug request.
- d_we  in  1  debug write (1) / read (0).
- d_lock  in  1  debug requests exclusive ownership.
- d_addr  in  ADDR_W  debug word address.
- d_wdata  in  DATA_W  debug write data.
- d_gnt  out  1  debug request accepted this cycle.
- d_rvalid  out  1  debug read data valid.
- d_rdata  out  DATA_W  debug read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Clears wait_cnt, lock_active and the return tag.
  - While rst_n=0, f_gnt, d_gnt, mem_en, mem_we, f_rvalid and d_rvalid are forced to 0.
  - Reset asserted one cycle after a read grant drops that read's rvalid; no stale data is delivered.
- Grant is combinational in the request cycle. A requester holds req, addr, we and wdata stable until its gnt.
- Arbitration, each cycle, first match wins:
  1. lock_active=1: f_gnt=0; d_gnt=d_req.
  2. Only one requester active: that requester is granted.
  3. Both active and wait_cnt==MAX_WAIT: debug granted.
  4. Both active otherwise: fetch granted.
- Memory outputs:
  - On any grant: mem_en=1 and mem_addr is the granted address.
  - mem_we=1 only for a debug grant with d_we=1; mem_wdata=d_wdata.
  - No grant: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- wait_cnt (4-bit):
  - +1 when d_req=1 and d_gnt=0, saturating at MAX_WAIT.
  - Cleared on d_gnt or when d_req=0.
- Lock:
  - lock_active set on a cycle with d_gnt=1 and d_lock=1.
  - Cleared on the first edge with d_lock=0, regardless of d_req.
  - While locked and d_req=0, there is no memory access and fetch stalls.
- Return path:
  - A registered tag records owner (F/D) and read-ness of the granted access.
  - The cycle after a read grant, the owner's rvalid=1 and its rdata=mem_rdata.
  - The non-owner's rdata is 0. Both rdata are 0 when no rvalid.
  - Debug writes produce no rvalid.
- Throughput and latency:
  - One access per cycle; back-to-back grants allowed, including alternating owners.
  - Read latency is exactly 1 cycle.
- Simultaneous events:
  - A new grant in the same cycle as the previous read's rvalid is legal.
  - d_lock rising while fetch wins the cycle (rule 4) does not set the lock until debug is granted.

Test Plan:
- Reset then f_req=1, f_addr=0x010, mem holds 0x00500093 → f_gnt=1 same cycle, f_rvalid=1 and f_rdata=0x00500093 next cycle; d_rvalid=0, d_rdata=0.
- f_req held high every cycle, d_req=1 read of 0x1FF, MAX_WAIT=4 → debug denied 4 cycles, granted on the 5th; d_rvalid one cycle later; fetch resumes the following cycle.
- d_req=1, d_we=1, d_addr=0x004, d_wdata=0xDEADBEEF, then fetch read of 0x004 → mem_we=1 for one cycle, no d_rvalid; subsequent f_rdata=0xDEADBEEF.
- d_lock=1 with 3 writes interleaved with d_req=0 gaps, f_req=1 throughout → f_gnt=0 for the whole lock including gaps; f_gnt=1 the cycle after d_lock drops.
- Alternate fetch reads 0x000/0x001 with a debug read 0x002 back-to-back → each rvalid goes to the correct owner, 1-cycle latency, no data swap.
- rst_n=0 one cycle after a fetch read grant → f_rvalid stays 0; after release, wait_cnt=0 and lock_active=0 (verified by immediate fetch win under contention).
